// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side controller.
// Holds the controller state enum and skid depth.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } rd_state_e;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Downstream valid/ready stream carrying FIFO words.
// master drives valid/data, slave drives ready.
interface fifo_rd_ctrl_if #(
  parameter int WIDTH = 128
);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/fifo_rd_ctrl_skid.sv
// Two-entry skid FIFO absorbing the read latency.
// Ports: push/push_data in, pop in, cnt/head_data/not_empty out.
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       cnt,
  output logic [WIDTH-1:0] head_data,
  output logic             not_empty
);

  logic [WIDTH-1:0] mem0;
  logic [WIDTH-1:0] mem1;
  logic             wr_ptr;
  logic             rd_ptr;
  logic             pop_en;

  assign not_empty = (cnt != 2'd0);
  assign pop_en    = pop & not_empty;
  assign head_data = rd_ptr ? mem1 : mem0;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      mem0   <= '0;
      mem1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) mem1 <= push_data;
        else        mem0 <= push_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop_en) rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop_en);
    end
  end

  // The controller's credit check must keep us from
  // ever pushing into a full buffer without a pop.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (rstn)
    !(push && !pop_en && cnt == 2'(SKID_DEPTH))
  );

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Burst read controller: issues FIFO reads, streams words out.
// Ports: start/len/abort ctl, FIFO rden/rddata, dn stream, status.
module fifo_rd_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_burst_len,
  input  logic             i_abort,
  input  logic             i_fifo_empty,
  input  logic [WIDTH-1:0] i_fifo_rddata,
  output logic             o_fifo_rden,
  fifo_rd_ctrl_if.master   dn,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_aborted,
  output logic [CNT_W-1:0] o_xfer_cnt
);

  rd_state_e        state_q;
  rd_state_e        state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_d;
  logic [LEN_W-1:0] issued_q;
  logic [LEN_W-1:0] issued_d;
  logic             inflight_q;
  logic             aborted_q;
  logic             aborted_d;
  logic [CNT_W-1:0] xfer_q;

  logic [1:0]       skid_cnt;
  logic             pop;
  logic [2:0]       occ;
  logic             credit_ok;

  assign pop = dn.valid & dn.ready;

  // Words already committed to the skid once all
  // outstanding reads land, net of this cycle's pop.
  assign occ = {1'b0, skid_cnt}
             + {2'b00, inflight_q}
             - {2'b00, pop};
  assign credit_ok = (occ < 3'(SKID_DEPTH));

  assign o_fifo_rden = (state_q == READ)
                     & ~i_fifo_empty
                     & ~i_abort
                     & (issued_q < len_q)
                     & credit_ok;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    issued_d  = issued_q + LEN_W'(o_fifo_rden);
    aborted_d = aborted_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_burst_len != '0) begin
            len_d    = i_burst_len;
            issued_d = '0;
            state_d  = READ;
          end else begin
            state_d  = DONE;
          end
        end
      end
      READ: begin
        if (i_abort) begin
          aborted_d = 1'b1;
          state_d   = DRAIN;
        end else if (issued_q == len_q) begin
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && skid_cnt == 2'd0)
          state_d = DONE;
      end
      DONE: begin
        aborted_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      aborted_q  <= 1'b0;
      xfer_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      inflight_q <= o_fifo_rden;
      aborted_q  <= aborted_d;
      xfer_q     <= xfer_q + CNT_W'(pop);
    end
  end

  rd_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .push      (inflight_q),
    .push_data (i_fifo_rddata),
    .pop       (pop),
    .cnt       (skid_cnt),
    .head_data (dn.data),
    .not_empty (dn.valid)
  );

  assign o_busy     = (state_q != IDLE);
  assign o_done     = (state_q == DONE);
  assign o_aborted  = (state_q == DONE) & aborted_q;
  assign o_xfer_cnt = xfer_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a FIFO model
// and an expected-word scoreboard.
module tb_fifo_rd_ctrl;

  localparam int WIDTH = 128;
  localparam int LEN_W = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic [LEN_W-1:0] blen;
  logic             abort;
  logic             empty = 1'b1;
  logic [WIDTH-1:0] rddata = '0;
  logic             rden;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] xfer;

  fifo_rd_ctrl_if #(.WIDTH(WIDTH)) dn ();

  fifo_rd_ctrl #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_start       (start),
    .i_burst_len   (blen),
    .i_abort       (abort),
    .i_fifo_empty  (empty),
    .i_fifo_rddata (rddata),
    .o_fifo_rden   (rden),
    .dn            (dn),
    .o_busy        (busy),
    .o_done        (done),
    .o_aborted     (aborted),
    .o_xfer_cnt    (xfer)
  );

  always #5 clk = ~clk;

  // FIFO model: contents are words rd_total+1 .. wr_total.
  int               wr_total = 0;
  int               rd_total = 0;
  int               cyc = 0;
  logic             underflow = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rstn && rden) begin
      if (rd_total == wr_total) begin
        underflow = 1'b1;
      end else begin
        rddata <= WIDTH'(rd_total + 1);
        exp_q.push_back(WIDTH'(rd_total + 1));
        rd_total = rd_total + 1;
      end
    end
    empty <= (rd_total == wr_total);
  end

  int               tests = 0;
  int               fails = 0;
  int               exp_rd = 0;
  int               rden_cycs[$];
  int               pop_cycs[$];
  int               done_cycs[$];
  logic             last_ab = 1'b0;
  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] data_prev = '0;

  task automatic check_int(string tag, int obs, int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic check_data(string tag,
                            logic [WIDTH-1:0] obs,
                            logic [WIDTH-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic mon();
    int   pend;
    logic pop;
    if (rstn) begin
      stall_prev = 1'b0;
      return;
    end
    pend = exp_q.size() - exp_rd;
    pop  = dn.valid && dn.ready;
    if (rden) begin
      check_int("credit", int'(pend - int'(pop) < 2), 1);
      rden_cycs.push_back(cyc);
    end
    if (stall_prev) begin
      check_int("stall_valid", int'(dn.valid), 1);
      check_data("stall_data", dn.data, data_prev);
    end
    if (pop) begin
      if (pend == 0) begin
        check_int("pop_unexpected", 1, 0);
      end else begin
        check_data("data", dn.data, exp_q[exp_rd]);
        exp_rd++;
      end
      pop_cycs.push_back(cyc);
    end
    if (done) begin
      done_cycs.push_back(cyc);
      last_ab = aborted;
    end
    stall_prev = dn.valid && !dn.ready;
    data_prev  = dn.data;
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(int len);
    start = 1'b1;
    blen  = LEN_W'(len);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(int budget, string tag);
    int base;
    base = done_cycs.size();
    for (int i = 0; i < budget; i++) begin
      if (done_cycs.size() > base) break;
      step();
    end
    if (done_cycs.size() == base)
      check_int(tag, 0, 1);
  endtask

  initial begin
    int br;
    int bp;
    int bd;
    int cs;
    rstn     = 1'b1;
    start    = 1'b0;
    blen     = '0;
    abort    = 1'b0;
    dn.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_int("rst_valid", int'(dn.valid), 0);
    check_int("rst_rden", int'(rden), 0);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_done", int'(done), 0);
    check_int("rst_aborted", int'(aborted), 0);
    check_int("rst_xfer", int'(xfer), 0);
    check_data("rst_data", dn.data, '0);
    rstn = 1'b0;
    step();

    // Full-rate burst of 8.
    wr_total += 8;
    step();
    step();
    br = rden_cycs.size();
    bp = pop_cycs.size();
    bd = done_cycs.size();
    pulse_start(8);
    wait_done(60, "t1_timeout");
    repeat (3) step();
    check_int("t1_rden_n", rden_cycs.size() - br, 8);
    check_int("t1_pop_n", pop_cycs.size() - bp, 8);
    if (rden_cycs.size() - br >= 8)
      check_int("t1_rden_contig",
                rden_cycs[br+7] - rden_cycs[br], 7);
    if (pop_cycs.size() - bp >= 8) begin
      check_int("t1_pop_contig",
                pop_cycs[bp+7] - pop_cycs[bp], 7);
      if (rden_cycs.size() > br)
        check_int("t1_latency",
                  pop_cycs[bp] - rden_cycs[br], 2);
    end
    check_int("t1_done_n", done_cycs.size() - bd, 1);
    check_int("t1_aborted", int'(last_ab), 0);
    check_int("t1_xfer", int'(xfer), 8);
    check_int("t1_busy", int'(busy), 0);

    // Toggling backpressure.
    wr_total += 8;
    step();
    step();
    br = rden_cycs.size();
    bp = pop_cycs.size();
    bd = done_cycs.size();
    pulse_start(8);
    for (int i = 0; i < 100; i++) begin
      if (done_cycs.size() > bd) break;
      dn.ready = ~dn.ready;
      step();
    end
    if (done_cycs.size() == bd)
      check_int("t2_timeout", 0, 1);
    dn.ready = 1'b1;
    repeat (3) step();
    check_int("t2_rden_n", rden_cycs.size() - br, 8);
    check_int("t2_pop_n", pop_cycs.size() - bp, 8);
    check_int("t2_done_n", done_cycs.size() - bd, 1);
    check_int("t2_xfer", int'(xfer), 16);
    check_int("t2_pend", exp_q.size() - exp_rd, 0);

    // FIFO runs dry mid-burst, then refills.
    wr_total += 3;
    step();
    step();
    br = rden_cycs.size();
    bp = pop_cycs.size();
    bd = done_cycs.size();
    pulse_start(5);
    repeat (15) step();
    check_int("t3_rden_wait", rden_cycs.size() - br, 3);
    check_int("t3_pop_wait", pop_cycs.size() - bp, 3);
    check_int("t3_done_wait", done_cycs.size() - bd, 0);
    check_int("t3_busy_wait", int'(busy), 1);
    check_int("t3_rden_low", int'(rden), 0);
    wr_total += 2;
    wait_done(40, "t3_timeout");
    repeat (3) step();
    check_int("t3_rden_n", rden_cycs.size() - br, 5);
    check_int("t3_pop_n", pop_cycs.size() - bp, 5);
    check_int("t3_done_n", done_cycs.size() - bd, 1);
    check_int("t3_xfer", int'(xfer), 21);

    // Abort after four reads of a ten-word burst.
    wr_total += 10;
    step();
    step();
    br = rden_cycs.size();
    bp = pop_cycs.size();
    bd = done_cycs.size();
    pulse_start(10);
    for (int i = 0; i < 40; i++) begin
      if (rden_cycs.size() - br >= 4) break;
      step();
    end
    abort = 1'b1;
    wait_done(40, "t4_timeout");
    abort = 1'b0;
    repeat (3) step();
    check_int("t4_rden_n", rden_cycs.size() - br, 4);
    check_int("t4_pop_n", pop_cycs.size() - bp, 4);
    check_int("t4_done_n", done_cycs.size() - bd, 1);
    check_int("t4_aborted", int'(last_ab), 1);
    check_int("t4_busy", int'(busy), 0);
    check_int("t4_xfer", int'(xfer), 25);

    // Reset with two words parked in the skid.
    wr_total += 8;
    step();
    step();
    dn.ready = 1'b0;
    pulse_start(8);
    repeat (6) step();
    check_int("t5_pend", exp_q.size() - exp_rd, 2);
    check_int("t5_valid_pre", int'(dn.valid), 1);
    rstn = 1'b1;
    #1;
    check_int("t5_rst_valid", int'(dn.valid), 0);
    check_int("t5_rst_rden", int'(rden), 0);
    check_int("t5_rst_xfer", int'(xfer), 0);
    check_int("t5_rst_busy", int'(busy), 0);
    check_data("t5_rst_data", dn.data, '0);
    step();
    exp_rd   = exp_q.size();
    rstn     = 1'b0;
    dn.ready = 1'b1;
    step();
    br = rden_cycs.size();
    bd = done_cycs.size();
    cs = cyc;
    pulse_start(0);
    repeat (4) step();
    check_int("t5_done_n", done_cycs.size() - bd, 1);
    if (done_cycs.size() > bd)
      check_int("t5_done_cyc", done_cycs[bd] - cs, 1);
    check_int("t5_aborted", int'(last_ab), 0);
    check_int("t5_rden_n", rden_cycs.size() - br, 0);
    check_int("t5_xfer", int'(xfer), 0);
    check_int("fifo_underflow", int'(underflow), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
